mem_access_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register outputs. It turns the registered load/store control codes, ALU address and store data into a req/ack transaction on the data-memory port. It stalls the pipeline until the transaction completes, then returns a sign- or zero-extended load result to writeback. It also flags misaligned accesses without issuing them.

---
 rtl/mem_access_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store sequencer.
// Takes the registered EX/MEM load/store control codes, address and store data and
// runs one req/ack transaction on the data-memory port. The pipeline is held while
// the transaction is outstanding. A load result is returned sign- or zero-extended
// with a one-cycle valid pulse. Misaligned accesses are flagged and never issued.
// Optional feature macro: MEM_TIMEOUT_EN. When defined, a REQ-state watchdog of
// TIMEOUT_CYCLES cycles aborts a stuck request and pulses bus_error_out.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_read_in,
    input  logic [2:0]  mem_write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        w_is_store;
    logic        w_is_load;
    logic        w_op;
    logic        w_aligned;
    logic        w_issue;
    logic        w_abort;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;

    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic [2:0]  r_ld_f3;
    logic [1:0]  r_ld_off;

    // Select the addressed lane of the read word and extend it according to funct3.
    // Reserved funct3 codes fall through to the full word.
    function automatic logic [31:0] load_extend(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] rdata
    );
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = rdata[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extend = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_extend = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_extend = {24'h000000, lane_b};
            3'b101:  load_extend = {16'h0000, lane_h};
            default: load_extend = rdata;
        endcase
    endfunction

    assign w_load_ext = load_extend(r_ld_f3, r_ld_off, dmem_rdata);

    // Decode op kind (store has priority over load), access size and alignment
    always_comb begin
        w_is_store = mem_write_in[2];
        w_is_load  = mem_read_in[3] & ~mem_write_in[2];
        w_op       = w_is_store | w_is_load;
        w_size     = w_is_store ? mem_write_in[1:0] : mem_read_in[1:0];
        case (w_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~addr_in[0];
            default: w_aligned = (addr_in[1:0] == 2'b00);
        endcase
        w_issue = (r_state == S_IDLE) & w_op & w_aligned;
    end

    // Byte enables and lane-replicated write data for the access size
    always_comb begin
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << addr_in[1:0];
                w_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {addr_in[1], 1'b0};
                w_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data_in;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    // Watchdog fires on the last allowed REQ cycle; a same-cycle ack takes priority
    always_comb begin
        w_abort = (r_state == S_REQ) & ~dmem_ack & (r_cnt == CNT_LAST);
    end

    // Count REQ cycles spent waiting for ack, restarting on every new request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) && !dmem_ack && !w_abort) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // One-cycle bus error pulse, visible in the DONE cycle after an abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
        end
    end

    assign bus_error_out = r_bus_err;
`else
    // Without the watchdog a request simply waits for its ack
    always_comb begin
        w_abort = 1'b0;
    end

    assign bus_error_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: DONE always returns to IDLE so a held op is not re-issued
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = w_issue ? S_REQ : S_IDLE;
            S_REQ: begin
                if (dmem_ack || w_abort) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Combinational stall and misalignment flags; DONE releases the pipeline
    always_comb begin
        stall_out      = 1'b0;
        misaligned_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_out      = w_issue;
                misaligned_out = w_op & ~w_aligned;
            end
            S_REQ:   stall_out = 1'b1;
            default: stall_out = 1'b0;
        endcase
    end

    // Port registers: latch on issue, release on ack or abort, capture load results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0000_0000;
            r_be         <= 4'b0000;
            r_wdata      <= 32'h0000_0000;
            r_load_data  <= 32'h0000_0000;
            r_load_valid <= 1'b0;
            r_ld_f3      <= 3'b000;
            r_ld_off     <= 2'b00;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_req    <= 1'b1;
                        r_we     <= w_is_store;
                        r_addr   <= {addr_in[31:2], 2'b00};
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_ld_f3  <= mem_read_in[2:0];
                        r_ld_off <= addr_in[1:0];
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_load_data  <= w_load_ext;
                            r_load_valid <= 1'b1;
                        end
                    end else if (w_abort) begin
                        r_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_be        = r_be;
    assign dmem_wdata     = r_wdata;
    assign load_data_out  = r_load_data;
    assign load_valid_out = r_load_valid;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A transaction-level model derives the
// expected port values for every cycle from the access rules (alignment, lane
// arithmetic, latency); literal expectations pin the model on key vectors.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_read_in;
    logic [2:0]  mem_write_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        misaligned_out;
    logic        bus_error_out;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cnt_stall, cnt_req, cnt_mis, cnt_berr;

    logic        exp_stall, exp_mis, exp_req, exp_we, exp_valid, exp_berr;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_be;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .stall_out      (stall_out),
        .load_data_out  (load_data_out),
        .load_valid_out (load_valid_out),
        .misaligned_out (misaligned_out),
        .bus_error_out  (bus_error_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Access width in bytes from a size code (reserved codes behave as word).
    function automatic int access_bytes(input logic [1:0] code);
        if (code == 2'b00) return 1;
        else if (code == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic [3:0] model_be(input int nb, input logic [31:0] a);
        logic [31:0] v;
        v = ((32'h1 << nb) - 32'h1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] sd);
        if (nb == 1) return (sd & 32'h0000_00FF) * 32'h0101_0101;
        else if (nb == 2) return (sd & 32'h0000_FFFF) * 32'h0001_0001;
        else return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int          n;
        logic [31:0] mask, lane;
        if (f3 == 3'b000 || f3 == 3'b100) n = 1;
        else if (f3 == 3'b001 || f3 == 3'b101) n = 2;
        else return rd;
        mask = (32'h1 << (8 * n)) - 32'h1;
        lane = (rd >> (8 * (a % 4))) & mask;
        if (f3[2] == 1'b0 && lane[8 * n - 1]) lane = lane | ~mask;
        return lane;
    endfunction

    task automatic compare_all();
        chk("stall_out", 32'(stall_out), 32'(exp_stall));
        chk("misaligned_out", 32'(misaligned_out), 32'(exp_mis));
        chk("dmem_req", 32'(dmem_req), 32'(exp_req));
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        chk("dmem_wdata", dmem_wdata, exp_wdata);
        chk("load_valid_out", 32'(load_valid_out), 32'(exp_valid));
        chk("load_data_out", load_data_out, exp_ld);
        chk("bus_error_out", 32'(bus_error_out), 32'(exp_berr));
    endtask

    // Compare at the falling edge, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        cnt_stall += int'(stall_out);
        cnt_req   += int'(dmem_req);
        cnt_mis   += int'(misaligned_out);
        cnt_berr  += int'(bus_error_out);
        @(posedge clk);
        #1;
    endtask

    // One pipeline op held on the inputs until it completes, followed by one idle cycle.
    // wait_n >= 0: ack arrives in REQ cycle wait_n+1. wait_n < 0: never acked (timeout).
    task automatic run_op(input logic [2:0] wr, input logic [3:0] rd, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdata, input int wait_n);
        logic st, ld, al;
        int   nb, n_req;
        st = wr[2];
        ld = rd[3] & ~wr[2];
        nb = access_bytes(st ? wr[1:0] : rd[1:0]);
        al = ((a % nb) == 0);
        n_req = (wait_n >= 0) ? (wait_n + 1) : TMO;
        cnt_stall = 0; cnt_req = 0; cnt_mis = 0; cnt_berr = 0;
        mem_write_in = wr; mem_read_in = rd; addr_in = a; store_data_in = sd;
        dmem_rdata = rdata; dmem_ack = 1'b0;
        exp_stall = al; exp_mis = ~al; exp_req = 1'b0; exp_valid = 1'b0; exp_berr = 1'b0;
        step();
        if (al) begin
            exp_stall = 1'b1; exp_mis = 1'b0; exp_req = 1'b1; exp_we = st;
            exp_addr  = a & ~32'h3;
            exp_be    = model_be(nb, a);
            exp_wdata = model_wdata(nb, sd);
            for (int k = 0; k < n_req; k++) begin
                dmem_ack = (wait_n >= 0) && (k == wait_n);
                if (k == 0) begin
                    seen_addr = dmem_addr; seen_be = dmem_be;
                    seen_wdata = dmem_wdata; seen_we = dmem_we;
                end
                step();
            end
            dmem_ack  = 1'b0;
            exp_req   = 1'b0;
            exp_stall = 1'b0;
            exp_valid = ld && (wait_n >= 0);
            exp_berr  = (wait_n < 0);
            if (exp_valid) exp_ld = model_load(rd[2:0], a, rdata);
            step();
        end
        mem_write_in = 3'b000; mem_read_in = 4'b0000; addr_in = 32'h0; store_data_in = 32'h0;
        exp_stall = 1'b0; exp_mis = 1'b0; exp_valid = 1'b0; exp_berr = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        mem_read_in = 4'b0000; mem_write_in = 3'b000; addr_in = 32'h0; store_data_in = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        exp_stall = 1'b0; exp_mis = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_valid = 1'b0;
        exp_berr = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_ld = 32'h0; exp_be = 4'h0;
        #2;
        chk("reset_req", 32'(dmem_req), 32'h0);
        chk("reset_load_data", load_data_out, 32'h0);
        chk("reset_addr", dmem_addr, 32'h0);
        step();
        rst = 1'b0;
        step();

        // LW 0x100, ack in first REQ cycle
        run_op(3'b000, 4'b1010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        chk("lw_data", load_data_out, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", 32'(cnt_stall), 32'd2);
        chk("lw_req_cycles", 32'(cnt_req), 32'd1);
        chk("lw_addr", seen_addr, 32'h0000_0100);
        chk("lw_be", 32'(seen_be), 32'hF);

        // Byte/half loads from 0x80FF_1234
        run_op(3'b000, 4'b1000, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1);
        chk("lb_data", load_data_out, 32'hFFFF_FF80);
        run_op(3'b000, 4'b1100, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0);
        chk("lbu_data", load_data_out, 32'h0000_0080);
        run_op(3'b000, 4'b1101, 32'h0000_0202, 32'h0, 32'h80FF_1234, 0);
        chk("lhu_data", load_data_out, 32'h0000_80FF);
        run_op(3'b000, 4'b1001, 32'h0000_0202, 32'h0, 32'h80FF_1234, 0);
        chk("lh_data", load_data_out, 32'hFFFF_80FF);
        run_op(3'b000, 4'b1001, 32'h0000_0200, 32'h0, 32'h80FF_1234, 0);
        chk("lh_low_data", load_data_out, 32'h0000_1234);

        // Stores: load result must be held
        run_op(3'b100, 4'b0000, 32'h0000_0301, 32'h0000_00AB, 32'h0, 2);
        chk("sb_we", 32'(seen_we), 32'h1);
        chk("sb_be", 32'(seen_be), 32'h2);
        chk("sb_wdata", seen_wdata, 32'hABAB_ABAB);
        chk("sb_addr", seen_addr, 32'h0000_0300);
        chk("sb_ld_held", load_data_out, 32'h0000_1234);
        run_op(3'b101, 4'b0000, 32'h0000_0302, 32'h1234_CDEF, 32'h0, 0);
        chk("sh_be", 32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wdata, 32'hCDEF_CDEF);
        run_op(3'b110, 4'b0000, 32'h0000_0304, 32'h1234_5678, 32'h0, 1);

        // Misaligned accesses are flagged, never issued
        run_op(3'b000, 4'b1010, 32'h0000_0102, 32'h0, 32'h0, 0);
        chk("mis_lw_req", 32'(cnt_req), 32'd0);
        chk("mis_lw_stall", 32'(cnt_stall), 32'd0);
        chk("mis_lw_flag", 32'(cnt_mis), 32'd1);
        run_op(3'b101, 4'b0000, 32'h0000_0301, 32'h5555_AAAA, 32'h0, 0);
        run_op(3'b000, 4'b1001, 32'h0000_0203, 32'h0, 32'h0, 0);

        // Both enables: store wins (word store misaligned even though a byte load would not be)
        run_op(3'b110, 4'b1010, 32'h0000_0500, 32'hCAFE_F00D, 32'h7777_7777, 0);
        chk("both_we", 32'(seen_we), 32'h1);
        chk("both_ld_held", load_data_out, 32'h0000_1234);
        run_op(3'b110, 4'b1000, 32'h0000_0501, 32'hCAFE_F00D, 32'h0, 0);
        chk("both_mis_req", 32'(cnt_req), 32'd0);

        // Reserved funct3 returns the full word
        run_op(3'b000, 4'b1011, 32'h0000_0108, 32'h0, 32'h8765_4321, 0);
        chk("rsvd_data", load_data_out, 32'h8765_4321);

        // Ack after 5 wait cycles; ack landing exactly in the last watchdog cycle
        run_op(3'b000, 4'b1010, 32'h0000_0110, 32'h0, 32'h0BAD_F00D, 5);
        chk("wait_req_cycles", 32'(cnt_req), 32'd6);
        chk("wait_stall_cycles", 32'(cnt_stall), 32'd7);
        run_op(3'b000, 4'b1010, 32'h0000_0114, 32'h0, 32'h0BAD_F00D, 3);
        chk("edge_ack_berr", 32'(cnt_berr), 32'd0);

`ifdef MEM_TIMEOUT_EN
        run_op(3'b000, 4'b1010, 32'h0000_0400, 32'h0, 32'hFFFF_FFFF, -1);
        chk("to_req_cycles", 32'(cnt_req), 32'd4);
        chk("to_berr_pulses", 32'(cnt_berr), 32'd1);
        chk("to_ld_held", load_data_out, 32'h0BAD_F00D);
`endif

        // Reset in the third REQ cycle of a long load
        mem_read_in = 4'b1010; addr_in = 32'h0000_0600; dmem_rdata = 32'h1111_1111; dmem_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_valid = 1'b0;
        step();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0600; exp_be = 4'hF; exp_wdata = 32'h0;
        step();
        step();
        chk("rst_pre_req", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(dmem_req), 32'h0);
        chk("rst_async_addr", dmem_addr, 32'h0);
        mem_read_in = 4'b0000; addr_in = 32'h0; dmem_ack = 1'b1;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0;
        exp_wdata = 32'h0; exp_ld = 32'h0; exp_valid = 1'b0; exp_berr = 1'b0;
        step();
        rst = 1'b0;
        step();
        dmem_ack = 1'b0;
        step();
        run_op(3'b000, 4'b1010, 32'h0000_0104, 32'h0, 32'h0102_0304, 0);
        chk("post_rst_lw", load_data_out, 32'h0102_0304);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
